// File: rtl/binary_dilate.sv
// 3x3 binary dilation of a 1-bit video stream; 3-cycle latency on data and syncs.
// No backpressure: one pixel per clock; lines longer than H_ACT set sticky line_ovf.
module binary_dilate #(
  parameter int H_ACT = 480,
  parameter int V_ACT = 272
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_vs,
  input  logic din_hs,
  input  logic din_de,
  input  logic din_data,
  output logic dout_vs,
  output logic dout_hs,
  output logic dout_de,
  output logic dout_data,
  output logic line_ovf
);

  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

  logic [XW-1:0]   r_x;
  logic            r_x_full;
  logic [YW-1:0]   r_y;
  logic            r_de_d;
  logic            r_vs_d;
  logic            r_lb0 [H_ACT];
  logic            r_lb1 [H_ACT];
  logic [2:0][2:0] r_win;
  logic [2:0]      r_row;
  logic            r_or;
  logic [2:0]      r_vs_sr;
  logic [2:0]      r_hs_sr;
  logic [2:0]      r_de_sr;

  logic            w_de_rise;
  logic            w_de_fall;
  logic            w_vs_rise;
  logic            w_pix_ok;
  logic [2:0]      w_tap;

  assign w_de_rise = din_de & ~r_de_d;
  assign w_de_fall = ~din_de & r_de_d;
  assign w_vs_rise = din_vs & ~r_vs_d;
  assign w_pix_ok  = din_de & ~r_x_full;

  // Rows above the frame top read as background, so stale buffer contents never leak.
  assign w_tap[0] = w_pix_ok & (r_y >= YW'(2)) & r_lb1[r_x];
  assign w_tap[1] = w_pix_ok & (r_y >= YW'(1)) & r_lb0[r_x];
  assign w_tap[2] = w_pix_ok & din_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_x_full <= 1'b0;
      r_y      <= '0;
      r_de_d   <= 1'b0;
      r_vs_d   <= 1'b0;
      line_ovf <= 1'b0;
      r_win    <= '0;
      r_row    <= '0;
      r_or     <= 1'b0;
      r_vs_sr  <= '0;
      r_hs_sr  <= '0;
      r_de_sr  <= '0;
    end else begin
      r_de_d <= din_de;
      r_vs_d <= din_vs;

      if (din_de) begin
        if (r_x == X_LAST) begin
          r_x_full <= 1'b1;
        end else if (!r_x_full) begin
          r_x <= r_x + XW'(1);
        end
      end else if (w_de_fall) begin
        r_x      <= '0;
        r_x_full <= 1'b0;
      end

      // Frame-sync clear takes priority over the end-of-line increment.
      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_de_fall && (r_y != Y_LAST)) begin
        r_y <= r_y + YW'(1);
      end

      if (w_vs_rise) begin
        line_ovf <= 1'b0;
      end else if (din_de && r_x_full) begin
        line_ovf <= 1'b1;
      end

      for (int k = 0; k < 3; k++) begin
        if (din_de) begin
          r_win[k] <= w_de_rise ? {2'b00, w_tap[k]} : {r_win[k][1:0], w_tap[k]};
        end
        r_row[k] <= |r_win[k];
      end
      r_or <= |r_row;

      r_vs_sr <= {r_vs_sr[1:0], din_vs};
      r_hs_sr <= {r_hs_sr[1:0], din_hs};
      r_de_sr <= {r_de_sr[1:0], din_de};
    end
  end

  always_ff @(posedge clk) begin
    if (w_pix_ok) begin
      r_lb1[r_x] <= r_lb0[r_x];
      r_lb0[r_x] <= din_data;
    end
  end

  assign dout_vs   = r_vs_sr[2];
  assign dout_hs   = r_hs_sr[2];
  assign dout_de   = r_de_sr[2];
  assign dout_data = r_or & r_de_sr[2];

endmodule

// File: tb/tb_binary_dilate.sv
// Directed bench for binary_dilate: border, stale-buffer, overflow, reset and sync-delay cases.
module tb_binary_dilate;

  localparam int H = 16;
  localparam int V = 64;

  logic clk;
  logic rst_n;
  logic din_vs, din_hs, din_de, din_data;
  logic dout_vs, dout_hs, dout_de, dout_data, line_ovf;

  int   n_chk;
  int   n_err;
  // Expected-output pipeline, {vs, hs, de, data, data_checked}
  logic [4:0] pq [3];
  logic rst_cmd;
  logic last_vs;
  logic ovf_model;
  bit   ovf_valid;
  bit   rnd;

  binary_dilate #(.H_ACT(H), .V_ACT(V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_vs    (din_vs),
    .din_hs    (din_hs),
    .din_de    (din_de),
    .din_data  (din_data),
    .dout_vs   (dout_vs),
    .dout_hs   (dout_hs),
    .dout_de   (dout_de),
    .dout_data (dout_data),
    .line_ovf  (line_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic pix(input int mode, input int x, input int y);
    case (mode)
      1:       return 1'b1;
      2:       return (x == 10 && y == 10);
      3:       return ((x + 2 * y) % 5 == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Reference dilation over an image that is background outside the frame.
  function automatic logic gold(input int mode, input int x, input int y);
    logic r;
    r = 1'b0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        if (x - dx >= 0 && y - dy >= 0 && pix(mode, x - dx, y - dy)) r = 1'b1;
    return r;
  endfunction

  function automatic logic expd(input int mode, input int x, input int y);
    case (mode)
      1:       return 1'b1;
      2:       return (x >= 10 && x <= 12 && y >= 10 && y <= 12);
      3:       return gold(mode, x, y);
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle(input logic vs, input logic hs, input logic de, input logic d,
                       input logic ed, input logic cd, input logic ovp);
    @(negedge clk);
    chk("sync", 32'({dout_vs, dout_hs, dout_de}), 32'(pq[2][4:2]));
    if (pq[2][0]) chk("data", 32'(dout_data), 32'(pq[2][1]));
    if (ovf_valid) chk("ovf", 32'(line_ovf), 32'(ovf_model));
    if (!rst_cmd && rst_n) begin
      rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({dout_vs, dout_hs, dout_de, dout_data, line_ovf}), 32'd0);
      pq[0] = '0; pq[1] = '0; pq[2] = '0;
      ovf_model = 1'b0;
    end else begin
      rst_n = rst_cmd;
    end
    pq[2] = pq[1];
    pq[1] = pq[0];
    if (!rst_n) pq[0] = '0;
    else        pq[0] = {vs, hs, de, de ? ed : 1'b0, de ? cd : 1'b1};
    din_vs = vs; din_hs = hs; din_de = de; din_data = d;
    if (rst_n && !rnd) begin
      if (vs && !last_vs) begin
        ovf_model = 1'b0;
        ovf_valid = 1'b1;
      end else if (de && ovp) begin
        ovf_model = 1'b1;
      end
    end
    last_vs = vs;
  endtask

  task automatic frame(input int mode, input int nl, input int ovf_y, input int rst_y);
    logic cd;
    logic ed;
    int   w;
    cd = 1'b1;
    repeat (2) cycle(1, 0, 0, 0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
    for (int y = 0; y < nl; y++) begin
      cycle(0, 1, 0, 0, 0, 1, 0);
      repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
      w = (y == ovf_y) ? H + 5 : H;
      for (int x = 0; x < w; x++) begin
        if (y == rst_y && x == 5) begin
          rst_cmd = 1'b0;
          cd = 1'b0;
        end
        if (y == rst_y && x == 8) rst_cmd = 1'b1;
        // Overflow pixels contribute background; only two real columns remain in the window.
        ed = (x >= H + 2) ? 1'b0 : expd(mode, x, y);
        cycle(0, 0, 1, pix(mode, x, y), ed, cd, logic'(x >= H));
      end
      repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; rst_cmd = 1'b0;
    din_vs = 1'b0; din_hs = 1'b0; din_de = 1'b0; din_data = 1'b0;
    pq[0] = '0; pq[1] = '0; pq[2] = '0;
    last_vs = 1'b0; ovf_model = 1'b0; ovf_valid = 1'b1; rnd = 1'b0;

    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("rst_state", 32'({dout_vs, dout_hs, dout_de, dout_data, line_ovf}), 32'd0);
    rst_cmd = 1'b1;
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);

    frame(2, 14, -1, -1);
    frame(1, 14, -1, -1);
    frame(0, 14, -1, -1);
    frame(1, 6, 3, -1);
    frame(0, 3, -1, -1);

    rnd = 1'b1;
    ovf_valid = 1'b0;
    for (int i = 0; i < 300; i++)
      cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 1, 0);
    rnd = 1'b0;

    frame(3, 56, -1, 50);
    frame(3, 14, -1, -1);
    repeat (4) cycle(0, 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
